load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side load/store unit between the CPU core's memory-access signals and the data memory. It accepts one load or store request at a time over a valid/ready handshake. It converts byte addresses and RV32I access sizes (funct3) into word-addressed, byte-enabled memory cycles, and tolerates memory wait states via `mem_ready`. It sign- or zero-extends load data and returns a single-cycle response that flags misaligned or illegal accesses.

## Interface
Parameters:
- `ADDR_W`, default 10: width of the word address to data memory. Byte-address bits `[ADDR_W+1:2]` are used; higher bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RSTn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I size/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3; no memory access was made.
- `mem_en`  out  1  memory access request.
- `mem_we`  out  1  memory write.
- `mem_be`  out  4  byte enables; bit i covers `wdata[8i+7:8i]`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  lane-aligned write data.
- `mem_rdata`  in  32  read data, valid the cycle after the read is accepted.
- `mem_ready`  in  1  memory accepts the current `mem_en` cycle.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, all `req_*` fields are registered.
  - Legal request → ACCESS.
  - Error → RESP with `resp_err`=1.
- ACCESS:
  - `mem_en`=1 and `mem_we`=stored we; `mem_addr`/`mem_be`/`mem_wdata` are driven from registered fields.
  - Held unchanged until `mem_ready`=1.
  - On `mem_ready`: store → RESP; load → RDWAIT.
- RDWAIT:
  - `mem_en`=0.
  - `mem_rdata` is captured, shifted right by 8×addr[1:0], extended, and registered → RESP.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE. The core must take the response that cycle; there is no back-pressure.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an error.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0. Either raises an error.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << addr[1:0]`.
  - word: `4'b1111`.
- `mem_wdata`: byte replicated to all four lanes; halfword replicated to both halves; word as-is.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unchanged.
- `mem_be`=0 and `mem_wdata`=0 whenever `mem_en`=0.

## Timing
- Reset, asynchronous: state IDLE; `req_ready`=1; `resp_valid`, `resp_err`, `mem_en`, `mem_we`=0; `mem_be`, `mem_addr`, `mem_wdata`, `resp_rdata`=0.
- Reset mid-access: `mem_en` drops immediately and the request is discarded with no response. A store already accepted by memory (ACCESS with `mem_ready`=1 at an edge) is not undone.
- Latency, counting from the accept edge as cycle 0, with `mem_ready`=1:
  - store: ACCESS in cycle 1, `resp_valid` in cycle 2.
  - load: ACCESS 1, RDWAIT 2, `resp_valid` 3.
  - error: `resp_valid` in cycle 1 with no `mem_en` pulse.
- Each cycle of `mem_ready`=0 in ACCESS adds one cycle. Outputs stay stable during the stall.
- Throughput: at most one request per 3 (store) or 4 (load) cycles. `req_ready` returns in the cycle after RESP.
- `req_valid` outside IDLE is ignored; the requester must hold it.
- `resp_rdata`/`resp_err` are valid only while `resp_valid`=1. They hold their value afterwards but are not meaningful.

## Test plan
- Reset: assert RSTn=0 mid-ACCESS with `mem_ready`=0 → `mem_en`=0 the same cycle. After release, `req_ready`=1 and no `resp_valid` ever appears.
- SB to 0x0000_0006, wdata=0x0000_00A5 → `mem_addr`=1, `mem_be`=0100, `mem_wdata`=0xA5A5_A5A5, `resp_valid` at cycle 2, `resp_rdata`=0.
- LH then LHU at 0x0000_0002, memory word 0x8001_7FFF → 0xFFFF_8001, then 0x0000_8001, each at cycle 3.
- LB 0x0000_0003 over word 0x7F00_0000 → 0x0000_007F. LW at 0x0000_1004 with ADDR_W=10 → `mem_addr`=1 (wrap).
- LW at 0x0000_0002 → `resp_err`=1 at cycle 1 with no `mem_en`. funct3=011 store → `resp_err`=1.
- SW with `mem_ready` held low 3 cycles → `mem_en`/`mem_be`=1111/`mem_addr` stable for 4 cycles, `resp_valid` at cycle 5. `req_valid` held high throughout is accepted only once.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side bundles for the load/store unit.
// lsu_core_if: request/response handshake; lsu_mem_if: word-addressed data memory port.
interface lsu_core_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 10);
   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );
   modport slave (
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit: one request at a time, byte-enabled word memory cycles.
// Ports: CLK, RSTn (async low), core (lsu_core_if.slave), mem (lsu_mem_if.master).
module load_store_unit #(
   parameter int ADDR_W = 10
) (
   input logic        CLK,
   input logic        RSTn,
   lsu_core_if.slave  core,
   lsu_mem_if.master  mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

   state_t state, state_n;

   logic              we_r;
   logic [2:0]        f3_r;
   logic [ADDR_W+1:0] addr_r;
   logic [31:0]       wdata_r;
   logic              err_r;
   logic [31:0]       rdata_r;

   logic        bad_f3;
   logic        misal;
   logic        req_err;
   logic [3:0]  be;
   logic [31:0] wlane;
   logic [31:0] shifted;
   logic [31:0] ext;
   logic        en;

   always_comb begin
      bad_f3 = 1'b0;
      misal  = 1'b0;
      case (core.req_funct3)
         3'b000: bad_f3 = 1'b0;
         3'b001: misal  = core.req_addr[0];
         3'b010: misal  = |core.req_addr[1:0];
         3'b100: bad_f3 = core.req_we;
         3'b101: begin
            bad_f3 = core.req_we;
            misal  = core.req_addr[0];
         end
         default: bad_f3 = 1'b1;
      endcase
      req_err = bad_f3 | misal;
   end

   // Lane placement from the registered fields; size code 11 never reaches ACCESS.
   always_comb begin
      be    = 4'b1111;
      wlane = wdata_r;
      unique case (1'b1)
         (f3_r[1:0] == 2'b00): begin
            be    = 4'b0001 << addr_r[1:0];
            wlane = {4{wdata_r[7:0]}};
         end
         (f3_r[1:0] == 2'b01): begin
            be    = 4'b0011 << addr_r[1:0];
            wlane = {2{wdata_r[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = wdata_r;
         end
      endcase
   end

   assign shifted = mem.mem_rdata >> {addr_r[1:0], 3'b000};

   always_comb begin
      ext = shifted;
      case (f3_r)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'd0, shifted[7:0]};
         3'b101:  ext = {16'd0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:
            if (core.req_valid)
               state_n = req_err ? RESP : ACCESS;
         ACCESS:
            if (mem.mem_ready)
               state_n = we_r ? RESP : RDWAIT;
         RDWAIT:  state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         we_r    <= 1'b0;
         f3_r    <= 3'd0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         err_r   <= 1'b0;
         rdata_r <= 32'd0;
      end else if (state == IDLE && core.req_valid) begin
         we_r    <= core.req_we;
         f3_r    <= core.req_funct3;
         addr_r  <= core.req_addr[ADDR_W+1:0];
         wdata_r <= core.req_wdata;
         err_r   <= req_err;
         rdata_r <= 32'd0;
      end else if (state == RDWAIT) begin
         rdata_r <= ext;
      end
   end

   // Memory outputs are decoded from state so reset drops them at once.
   assign en            = (state == ACCESS);
   assign mem.mem_en    = en;
   assign mem.mem_we    = en & we_r;
   assign mem.mem_be    = en ? be : 4'd0;
   assign mem.mem_addr  = en ? addr_r[ADDR_W+1:2] : '0;
   assign mem.mem_wdata = en ? wlane : 32'd0;

   assign core.req_ready  = (state == IDLE);
   assign core.resp_valid = (state == RESP);
   assign core.resp_rdata = rdata_r;
   assign core.resp_err   = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit.
// Byte-array reference model; word memory with bench-controlled wait states.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lsu_core_if core ();
   lsu_mem_if #(.ADDR_W(10)) mem ();

   load_store_unit #(.ADDR_W(10)) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .core (core),
      .mem  (mem)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] mem_arr [0:1023];
   logic [7:0]  ref_b   [0:4095];
   logic [31:0] rd_q = 32'd0;

   assign mem.mem_rdata = rd_q;

   always @(posedge clk) begin
      if (mem.mem_en && mem.mem_ready) begin
         if (mem.mem_we) begin
            for (int i = 0; i < 4; i++)
               if (mem.mem_be[i])
                  mem_arr[mem.mem_addr][8*i +: 8] <= mem.mem_wdata[8*i +: 8];
         end else begin
            rd_q <= mem_arr[mem.mem_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      mem_arr[idx] = v;
      for (int i = 0; i < 4; i++) ref_b[4*idx + i] = v[8*i +: 8];
   endtask

   function automatic bit legal(input bit we, input logic [2:0] f3,
                                input logic [31:0] a);
      case (f3)
         3'd0: return 1'b1;
         3'd1: return !a[0];
         3'd2: return a[1:0] == 2'b00;
         3'd4: return !we;
         3'd5: return !we && !a[0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'd0) return 1;
      if (f3[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input logic [31:0] a);
      int b;
      logic [31:0] v;
      b = int'(a[11:0]);
      v = 32'd0;
      for (int i = 0; i < nbytes(f3); i++)
         v = v | (32'(ref_b[b + i]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic run(input string tag, input bit we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int stalls);
      bit          err;
      int          nb, off, lat, exp_lat, en_cnt, bad;
      logic [31:0] exp_rd, ewd, got_rd;
      logic [3:0]  ebe;
      logic [9:0]  eaddr;
      logic        got_err;
      err   = !legal(we, f3, addr);
      nb    = nbytes(f3);
      off   = int'(addr[1:0]);
      ebe   = (nb == 4) ? 4'hF : 4'((((1 << nb) - 1) << off) & 15);
      ewd   = (nb == 1) ? {4{wdata[7:0]}} :
              (nb == 2) ? {2{wdata[15:0]}} : wdata;
      eaddr = addr[11:2];
      exp_rd  = (err || we) ? 32'd0 : ref_load(f3, addr);
      exp_lat = err ? 1 : (we ? stalls + 2 : stalls + 3);
      @(negedge clk);
      core.req_valid  = 1'b1;
      core.req_we     = we;
      core.req_funct3 = f3;
      core.req_addr   = addr;
      core.req_wdata  = wdata;
      mem.mem_ready   = (stalls == 0);
      chk({tag, "_rdy"}, 32'(core.req_ready), 32'd1);
      @(posedge clk);
      lat = -1; en_cnt = 0; bad = 0;
      got_rd = 32'hx; got_err = 1'bx;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(negedge clk);
         mem.mem_ready = (c > stalls);
         if (mem.mem_en) begin
            en_cnt++;
            if (mem.mem_we !== we || mem.mem_be !== ebe ||
                mem.mem_addr !== eaddr || mem.mem_wdata !== ewd)
               bad++;
         end else if (mem.mem_be !== 4'd0 || mem.mem_wdata !== 32'd0) begin
            bad++;
         end
         if (core.resp_valid) begin
            lat = c;
            got_rd = core.resp_rdata;
            got_err = core.resp_err;
            core.req_valid = 1'b0;
         end
      end
      core.req_valid = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"}, 32'(got_err), 32'(err));
      chk({tag, "_rdata"}, got_rd, exp_rd);
      chk({tag, "_en_cycles"}, 32'(en_cnt), err ? 32'd0 : 32'(stalls + 1));
      chk({tag, "_membus"}, 32'(bad), 32'd0);
      if (!err && we)
         for (int i = 0; i < nb; i++)
            ref_b[(int'(addr[11:0]) + i) & 4095] = wdata[8*i +: 8];
   endtask

   initial begin
      int resp_seen;
      logic [2:0] f3;
      logic [2:0] lf3 [0:4];
      lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2;
      lf3[3] = 3'd4; lf3[4] = 3'd5;
      core.req_valid = 1'b0;
      core.req_we = 1'b0;
      core.req_funct3 = 3'd0;
      core.req_addr = 32'd0;
      core.req_wdata = 32'd0;
      mem.mem_ready = 1'b1;
      for (int i = 0; i < 1024; i++) set_word(i, $urandom);

      #12;
      chk("rst_req_ready", 32'(core.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(core.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(core.resp_err), 32'd0);
      chk("rst_resp_rdata", core.resp_rdata, 32'd0);
      chk("rst_mem_en", 32'(mem.mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem.mem_we), 32'd0);
      chk("rst_mem_be", 32'(mem.mem_be), 32'd0);
      chk("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
      chk("rst_mem_wdata", mem.mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("sb6", 1'b1, 3'd0, 32'h0000_0006, 32'h0000_00A5, 0);
      set_word(0, 32'h8001_7FFF);
      run("lh2", 1'b0, 3'd1, 32'h0000_0002, 32'd0, 0);
      run("lhu2", 1'b0, 3'd5, 32'h0000_0002, 32'd0, 0);
      set_word(0, 32'h7F00_0000);
      run("lb3", 1'b0, 3'd0, 32'h0000_0003, 32'd0, 0);
      run("lw_wrap", 1'b0, 3'd2, 32'h0000_1004, 32'd0, 0);
      run("lw_mis", 1'b0, 3'd2, 32'h0000_0002, 32'd0, 0);
      run("s_f3_011", 1'b1, 3'd3, 32'h0000_0000, 32'h1234_5678, 0);
      run("sw_stall", 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 3);
      run("lw_back", 1'b0, 3'd2, 32'h0000_0010, 32'd0, 1);

      // Reset while a store is stalled in ACCESS.
      @(negedge clk);
      core.req_valid = 1'b1;
      core.req_we = 1'b1;
      core.req_funct3 = 3'd2;
      core.req_addr = 32'h0000_0020;
      core.req_wdata = 32'hCAFE_F00D;
      mem.mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_pre_en", 32'(mem.mem_en), 32'd1);
      rst_n = 1'b0;
      core.req_valid = 1'b0;
      #1;
      chk("rst_mid_en", 32'(mem.mem_en), 32'd0);
      chk("rst_mid_be", 32'(mem.mem_be), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem.mem_ready = 1'b1;
      resp_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (core.resp_valid) resp_seen++;
      end
      chk("rst_mid_ready", 32'(core.req_ready), 32'd1);
      chk("rst_mid_noresp", 32'(resp_seen), 32'd0);
      run("lw_after_rst", 1'b0, 3'd2, 32'h0000_0020, 32'd0, 0);

      for (int t = 0; t < 200; t++) begin
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else f3 = lf3[$urandom_range(0, 4)];
         run("rnd", 1'($urandom_range(0, 1)), f3, $urandom, $urandom,
             int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
